// File: rtl/frame_tagger_pkg.sv
// Shared definitions for the frame tagger: default widths/depth and the
// input-side FSM state type.
package frame_tagger_pkg;

  localparam int DWIDTH_DEF = 10;
  localparam int VWIDTH_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

endpackage

// File: rtl/tag_fifo.sv
// Show-ahead FIFO holding tagged words.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_push, i_wdata    write request and entry (ignored when full)
//   i_pop              read request (ignored when empty)
//   o_rdata            head entry, zero while empty
//   o_full, o_empty    occupancy flags
module tag_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AWIDTH = $clog2(DEPTH);
  localparam int CWIDTH = AWIDTH + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [CWIDTH-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CWIDTH'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  // Gate the head so a stale entry never leaks out while empty or in reset.
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CWIDTH'(1);
        2'b01:   r_count <= r_count - CWIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frame_tagger.sv
// Frame tagger: marks first/last word of each input frame and buffers the
// tagged words in a FIFO; counts frames leaving the block.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_vld, in_data, in_len, in_rdy  input stream (in_len read on first word)
//   out_vld, out_data, out_sop,
//   out_eop, out_rdy                 tagged output stream
//   frm_cnt                          completed (popped) frames, wraps at 256
//   busy                             input side is inside a frame
//
// state | meaning
// IDLE  | next accepted word starts a frame
// BODY  | mid-frame, r_remaining words still expected
module frame_tagger
  import frame_tagger_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int VWIDTH = VWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DWIDTH-1:0] in_data,
  input  logic [VWIDTH-1:0] in_len,
  output logic              in_rdy,
  output logic              out_vld,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_rdy,
  output logic [7:0]        frm_cnt,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [VWIDTH-1:0]   r_remaining;
  logic [VWIDTH-1:0]   w_remaining_nxt;
  logic                w_sop;
  logic                w_eop;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                r_rdy_en;
  logic [7:0]          r_frm_cnt;
  logic [DWIDTH+1:0]   w_head;

  // r_rdy_en holds in_rdy low during reset and rises on the first edge after.
  assign in_rdy  = r_rdy_en & ~w_full;
  assign w_push  = in_vld & in_rdy;
  assign out_vld = ~w_empty;
  assign w_pop   = out_vld & out_rdy;
  assign {out_sop, out_eop, out_data} = w_head;
  assign busy    = (r_state == BODY);
  assign frm_cnt = r_frm_cnt;

  // in_len = 0 wraps to remaining = 2^VWIDTH-1, i.e. a full-length frame.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_sop           = 1'b0;
    w_eop           = 1'b0;
    case (r_state)
      IDLE: begin
        w_sop = 1'b1;
        w_eop = (in_len == VWIDTH'(1));
        if (w_push) begin
          w_remaining_nxt = in_len - VWIDTH'(1);
          if (!w_eop) w_state_nxt = BODY;
        end
      end
      BODY: begin
        w_eop = (r_remaining == VWIDTH'(1));
        if (w_push) begin
          w_remaining_nxt = r_remaining - VWIDTH'(1);
          if (w_eop) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_rdy_en    <= 1'b0;
      r_frm_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_rdy_en    <= 1'b1;
      if (w_pop && out_eop) r_frm_cnt <= r_frm_cnt + 8'd1;
    end
  end

  tag_fifo #(
    .WIDTH (DWIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({w_sop, w_eop, in_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_frame_tagger.sv
module tb_frame_tagger;

  localparam int DW = 10;
  localparam int VW = 4;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic [DW-1:0] in_data;
  logic [VW-1:0] in_len;
  logic          in_rdy;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          out_rdy;
  logic [7:0]    frm_cnt;
  logic          busy;

  frame_tagger #(.DWIDTH(DW), .VWIDTH(VW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_rdy   (in_rdy),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_rdy  (out_rdy),
    .frm_cnt  (frm_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents as {sop, eop, data}, words still
  // owed to the current input frame, popped-frame count, ready-after-reset.
  logic [DW+1:0] q[$];
  int            words_left = 0;
  int            m_frm = 0;
  bit            m_rdy_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after a falling edge, check outputs against
  // the model, then advance the model by what the handshakes do at posedge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [VW-1:0] l,
                     input bit ordy, output bit acc);
    bit            exp_rdy;
    bit            pop;
    int            len;
    logic [DW+1:0] w;
    in_vld  = v;
    in_data = d;
    in_len  = l;
    out_rdy = ordy;
    #1;
    exp_rdy = m_rdy_en && (q.size() < DP);
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    chk("out_vld", 32'(out_vld), 32'(q.size() > 0));
    chk("busy", 32'(busy), 32'(words_left > 0));
    chk("frm_cnt", 32'(frm_cnt), 32'(m_frm));
    if (q.size() > 0) begin
      w = q[0];
      chk("out_sop", 32'(out_sop), 32'(w[DW+1]));
      chk("out_eop", 32'(out_eop), 32'(w[DW]));
      chk("out_data", 32'(out_data), 32'(w[DW-1:0]));
    end
    acc = v && exp_rdy;
    pop = ordy && (q.size() > 0);
    @(posedge clk);
    if (pop) begin
      w = q.pop_front();
      if (w[DW]) m_frm = (m_frm + 1) % 256;
    end
    if (acc) begin
      if (words_left == 0) begin
        len = (l == 0) ? 16 : int'(l);
        words_left = len - 1;
        w = {1'b1, (words_left == 0), d};
      end else begin
        words_left--;
        w = {1'b0, (words_left == 0), d};
      end
      q.push_back(w);
    end
    m_rdy_en = 1;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must settle at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_sop", 32'(out_sop), 32'd0);
    chk("rst_out_eop", 32'(out_eop), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frm_cnt", 32'(frm_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    q.delete();
    words_left = 0;
    m_frm = 0;
    m_rdy_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    int sent;
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_len  = '0;
    out_rdy = 1'b0;
    @(negedge clk);
    do_reset();

    // Single-word frame; first cycle after reset cannot accept.
    cyc(1'b0, '0, '0, 1'b1, acc);
    cyc(1'b1, DW'('h155), VW'(1), 1'b1, acc);
    cyc(1'b0, '0, '0, 1'b1, acc);
    cyc(1'b0, '0, '0, 1'b1, acc);
    chk("s1_frm_cnt", 32'(frm_cnt), 32'd1);

    // Length-0 frame: 16 words.
    for (int i = 0; i < 16; i++)
      cyc(1'b1, DW'($urandom), (i == 0) ? VW'(0) : VW'($urandom), 1'b1, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, acc);
    chk("s2_frm_cnt", 32'(frm_cnt), 32'd2);

    // Backpressure: 9-word frame into an 8-deep FIFO with out_rdy low.
    sent = 0;
    for (int k = 0; k < 30; k++) begin
      cyc(sent < 9, DW'(sent + 'h40), (sent == 0) ? VW'(9) : VW'($urandom), k >= 10, acc);
      if (acc) sent++;
    end
    chk("s3_frm_cnt", 32'(frm_cnt), 32'd3);

    // Length changes mid-frame are ignored.
    cyc(1'b1, DW'('h11), VW'(3), 1'b1, acc);
    cyc(1'b1, DW'('h22), VW'(7), 1'b1, acc);
    cyc(1'b1, DW'('h33), VW'(7), 1'b1, acc);
    cyc(1'b0, '0, VW'(7), 1'b1, acc);
    chk("s4_busy", 32'(busy), 32'd0);
    cyc(1'b0, '0, '0, 1'b1, acc);
    chk("s4_frm_cnt", 32'(frm_cnt), 32'd4);

    // Reset after 2 of 5 words; truncated frame is discarded.
    cyc(1'b1, DW'('h0a1), VW'(5), 1'b0, acc);
    cyc(1'b1, DW'('h0a2), VW'(5), 1'b0, acc);
    do_reset();
    cyc(1'b1, DW'('h0b1), VW'(2), 1'b1, acc);
    cyc(1'b1, DW'('h0b1), VW'(2), 1'b1, acc);
    cyc(1'b1, DW'('h0b2), VW'(2), 1'b1, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, acc);
    chk("s5_frm_cnt", 32'(frm_cnt), 32'd1);

    // 256 single-word frames wrap the frame counter back to 0.
    do_reset();
    cyc(1'b0, '0, '0, 1'b1, acc);
    for (int i = 0; i < 256; i++) cyc(1'b1, DW'(i), VW'(1), 1'b1, acc);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, acc);
    chk("s6_frm_wrap", 32'(frm_cnt), 32'd0);

    // Random traffic with random lengths and backpressure.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, DW'($urandom), VW'($urandom),
          $urandom_range(0, 1) == 1, acc);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, '0, 1'b1, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_tagger.md
FRAME_TAGGER -- requirements
Module: frame_tagger

Interface
REQ-001 Parameter DWIDTH, default 10: width of one data word.
REQ-002 Parameter VWIDTH, default 4: width of the frame-length field.
REQ-003 Parameter DEPTH, default 8: number of FIFO entries; SHALL be a power of two and at least 2.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_vld, input, 1: upstream word valid.
REQ-007 Port in_data, input, DWIDTH: upstream word.
REQ-008 Port in_len, input, VWIDTH: frame length in words; sampled only on the first word of a frame.
REQ-009 Port in_rdy, output, 1: block can accept a word.
REQ-010 Port out_vld, output, 1: output word valid.
REQ-011 Port out_data, output, DWIDTH: output word.
REQ-012 Port out_sop, output, 1: output word is the first word of a frame.
REQ-013 Port out_eop, output, 1: output word is the last word of a frame.
REQ-014 Port out_rdy, input, 1: downstream accepts the word.
REQ-015 Port frm_cnt, output, 8: count of completed frames.
REQ-016 Port busy, output, 1: block is mid-frame on the input side.

Function
REQ-017 Input handshake: a word is accepted in any cycle where in_vld=1 and in_rdy=1.
REQ-018 Input ready: in_rdy SHALL be 1 exactly when the FIFO is not full; there is no same-cycle pass-through when full, even if a pop happens that cycle.
REQ-019 Input FSM has two states, IDLE and BODY; reset state is IDLE.
REQ-020 IDLE: on an accepted word, load remaining = in_len-1.
- in_len=0 SHALL mean a 16-word frame (2^VWIDTH), so remaining = 15.
- Tag the word sop=1; tag it eop=1 if the frame length is 1.
- Go to BODY unless the word was eop.
REQ-021 BODY: on each accepted word, decrement remaining.
- The word with remaining=1 before its decrement is tagged eop=1.
- After the eop word, return to IDLE.
- in_len is ignored in BODY.
REQ-022 busy SHALL equal (state==BODY).
REQ-023 FIFO: each entry holds {sop, eop, data}, DWIDTH+2 bits; the FIFO is show-ahead.
REQ-024 Output handshake: out_vld = FIFO not empty; out_data, out_sop and out_eop come from the head entry; pop when out_vld=1 and out_rdy=1.
REQ-025 Latency: a word accepted on edge N SHALL be visible on out_* after edge N, i.e. one cycle, when the FIFO was empty.
REQ-026 Simultaneous push and pop on a non-full, non-empty FIFO: the occupancy is unchanged and ordering is preserved.
REQ-027 Pointers SHALL wrap modulo DEPTH; the occupancy counter is clog2(DEPTH)+1 bits wide.
REQ-028 frm_cnt increments on each popped word with eop=1 and wraps from 255 to 0.
REQ-029 Output stability: while out_vld=1 and out_rdy=0, out_data, out_sop and out_eop SHALL hold stable.

Reset
REQ-030 Asserting rst_n low at any time, including mid-frame, SHALL immediately:
- clear the FSM to IDLE and zero remaining;
- zero the pointers and occupancy;
- drive in_rdy=0, out_vld=0, out_sop=0, out_eop=0, out_data=0, frm_cnt=0, busy=0.
REQ-031 On the first edge after rst_n deasserts, in_rdy SHALL be 1; a frame truncated by reset is discarded and never emitted.

Structure
REQ-032 DWIDTH, VWIDTH, DEPTH defaults and the FSM state typedef (IDLE, BODY) SHALL live in the shared writer package.
REQ-033 The FIFO SHALL be the sub-module tag_fifo, parameterised by width and DEPTH; the FSM and frm_cnt stay in frame_tagger.

Verification
REQ-034 Scenario, single-word frame: reset, then push in_len=1, data=0x155 with out_rdy=1 -> one cycle later sop=1, eop=1, data=0x155; then frm_cnt=1.
REQ-035 Scenario, length-0 frame: push a frame with in_len=0 -> exactly 16 words out, sop on word 0 and eop on word 15 only; busy=1 from word 1 through word 15.
REQ-036 Scenario, backpressure: out_rdy=0 while pushing 9 words of a frame with in_len=9 -> in_rdy=0 after the 8th accept and out_* held stable; raise out_rdy -> all 9 words out in order, eop on the 9th.
REQ-037 Scenario, mid-frame length change: frame with in_len=3 while in_len changes to 7 on words 2-3 -> eop on word 3; busy falls.
REQ-038 Scenario, reset mid-frame: assert rst_n low after 2 of 5 words -> outputs reach reset values without a clock edge; next frame with in_len=2 is emitted correctly with frm_cnt=1.
REQ-039 Scenario, counter wrap: 256 frames with in_len=1 -> frm_cnt returns to 0.
